rx_frame_buf: RTL

RX_FRAME_BUF -- requirements
Module: rx_frame_buf

---
 rtl/rx_frame_buf.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rx_frame_buf.sv
// Receive frame buffer: stores decoder bytes and exposes only committed frames, first-word fall-through.
// Optional RX_FRAME_BUF_FCS_FILTER_EN: a COMPLETE with bad FCS discards the frame instead of committing it.
module rx_frame_buf #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_ev_sig,
    input  logic [2:0]        i_ev,
    input  logic [7:0]        i_byte,
    input  logic              i_fcs_ok,
    output logic [7:0]        o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_frame_done,
    output logic [7:0]        o_drop_cnt,
    output logic [ADDR_W:0]   o_level
);

    // Event codes, identical to the SYM_DEC_EV_* values of sym_dec.vh
    localparam logic [2:0] SYM_DEC_EV_PREAMBLE = 3'd1;
    localparam logic [2:0] SYM_DEC_EV_SFD      = 3'd2;
    localparam logic [2:0] SYM_DEC_EV_PHR      = 3'd3;
    localparam logic [2:0] SYM_DEC_EV_BYTE     = 3'd4;
    localparam logic [2:0] SYM_DEC_EV_COMPLETE = 3'd5;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t          state, state_nxt;
    logic            ev_q;
    logic [ADDR_W:0] wptr, cptr, rptr;
    logic [ADDR_W:0] wptr_nxt, cptr_nxt, base;
    logic [7:0]      mem [0:(1<<ADDR_W)-1];
    logic            ev_acc, is_pre, is_sfd, is_phr, is_byte, is_cmp;
    logic            fcs_bad, wr_try, full, abort, commit;
    logic            wr_en, done_nxt;
    logic [1:0]      drop_inc;
    logic [8:0]      drop_sum;

    assign ev_acc  = i_ev_sig & ~ev_q;
    assign is_pre  = ev_acc && (i_ev == SYM_DEC_EV_PREAMBLE);
    assign is_sfd  = ev_acc && (i_ev == SYM_DEC_EV_SFD);
    assign is_phr  = ev_acc && (i_ev == SYM_DEC_EV_PHR);
    assign is_byte = ev_acc && (i_ev == SYM_DEC_EV_BYTE);
    assign is_cmp  = ev_acc && (i_ev == SYM_DEC_EV_COMPLETE);

`ifdef RX_FRAME_BUF_FCS_FILTER_EN
    assign fcs_bad = ~i_fcs_ok;
`else
    assign fcs_bad = ~i_fcs_ok & 1'b0;
`endif

    // A PHR always (re)starts a frame at the commit pointer; outside RECV wptr already equals cptr.
    assign wr_try = is_phr | ((state == RECV) & is_byte);
    assign base   = is_phr ? cptr : wptr;
    assign full   = (base - rptr) == DEPTH;
    assign abort  = (state == RECV) & (is_pre | is_sfd | is_phr | (is_cmp & fcs_bad));
    assign commit = (state == RECV) & is_cmp & ~fcs_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (is_phr) state_nxt = full ? DROP : RECV;
            RECV: begin
                if (wr_try)               state_nxt = full ? DROP : RECV;
                else if (abort | commit)  state_nxt = IDLE;
            end
            DROP: begin
                if (is_phr)               state_nxt = full ? DROP : RECV;
                else if (is_cmp | is_pre) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en    = 1'b0;
        wptr_nxt = wptr;
        cptr_nxt = cptr;
        drop_inc = 2'd0;
        done_nxt = 1'b0;
        if (abort) begin
            wptr_nxt = cptr;
            drop_inc = 2'd1;
        end
        if (commit) begin
            cptr_nxt = wptr;
            done_nxt = 1'b1;
        end
        // A restart PHR can both abort the old frame and hit a full buffer: two drops.
        if (wr_try) begin
            if (full) begin
                wptr_nxt = cptr;
                drop_inc = drop_inc + 2'd1;
            end else begin
                wr_en    = 1'b1;
                wptr_nxt = base + 1'b1;
            end
        end
    end

    assign drop_sum = {1'b0, o_drop_cnt} + {7'd0, drop_inc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_q         <= 1'b0;
            wptr         <= '0;
            cptr         <= '0;
            rptr         <= '0;
            o_frame_done <= 1'b0;
            o_drop_cnt   <= 8'd0;
        end else begin
            ev_q         <= i_ev_sig;
            wptr         <= wptr_nxt;
            cptr         <= cptr_nxt;
            o_frame_done <= done_nxt;
            o_drop_cnt   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (o_valid && i_ready) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[base[ADDR_W-1:0]] <= i_byte;
    end

    assign o_valid = (cptr != rptr);
    assign o_level = cptr - rptr;
    assign o_data  = mem[rptr[ADDR_W-1:0]];

endmodule
